mem_llsc_unit: RTL and testbench
================================

// Module: mem_llsc_unit
// PURPOSE
//  MEM-stage load/store unit: runs LB/LBU/LH/LHU/LW/SB/SH/SW/LL/SC on the data bus with a req/ack handshake.
//  Stalls the pipeline while a bus access is outstanding.
//  Produces the write-back result and the LLbit update (we/value) carried via MEM/WB to the LLbit register.
//  Reads the current LLbit from the LLbit register read port, which already forwards pending WB writes.
// PARAMETERS
//  ACK_TIMEOUT  255  max cycles waiting for dbus_ack before bus_err; 0 = wait forever
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous reset, active-low
//  flush          in   1   exception flush; discard current MEM instruction
//  mem_valid      in   1   MEM stage holds a valid instruction
//  mem_op         in   4   memory op code (package constants); OP_NONE = pass-through
//  mem_addr       in   32  effective address
//  mem_wdata      in   32  store data (rt)
//  alu_result     in   32  result forwarded for non-memory ops
//  LLbit_i        in   1   current LLbit (LLbit register read port)
//  dbus_ack       in   1   bus transfer complete; dbus_rdata valid on this cycle
//  dbus_rdata     in   32  load data
//  dbus_req       out  1   bus request, registered
//  dbus_we        out  1   1 = write
//  dbus_addr      out  32  word-aligned address {mem_addr[31:2],2'b00}
//  dbus_sel       out  4   byte lanes, big-endian: addr[1:0]=0 -> 4'b1000
//  dbus_wdata     out  32  store data replicated into the selected lanes
//  wdata_o        out  32  write-back result
//  stallreq       out  1   stall IF..MEM this cycle
//  LLbit_we_o     out  1   LLbit write enable to MEM/WB
//  LLbit_value_o  out  1   LLbit write value
//  bus_err        out  1   1-cycle pulse on ack timeout
// BEHAVIOUR
//  Reset: state IDLE; dbus_req, dbus_we, dbus_sel, dbus_addr, dbus_wdata, wdata_o, LLbit_we_o, bus_err all 0.
//  Reset is asynchronous: asserting it mid-transfer drops dbus_req immediately.
//  States: IDLE, BUS, DONE, DRAIN.
//  IDLE, mem_valid, bus op, !flush:
//    - stallreq=1 (combinational); address/data/sel latched; next state BUS.
//    - Bus op = any load/store; SC only when LLbit_i=1.
//  BUS: dbus_req=1; outputs held stable until dbus_ack.
//    - ack -> DONE; rdata is latched and extended.
//    - flush during BUS -> DRAIN.
//  DRAIN: keep dbus_req until ack (the bus cannot be aborted); discard the result; no LLbit write; ->IDLE.
//  DONE: stallreq=0; wdata_o valid; LLbit pulse issued; ->IDLE. Memory op minimum latency = 3 cycles.
//  LL: LLbit_we_o=1, value 1.
//  SC:
//    - LLbit=1: store word; wdata_o=1; LLbit_we_o=1, value 0.
//    - LLbit=0: no bus access; wdata_o=0; no stall; 0 extra cycles.
//  Loads: sign-extend (LB/LH) or zero-extend (LBU/LHU) from the addressed big-endian lane.
//  Non-memory ops: wdata_o=alu_result, no stall, no LLbit write.
//  flush in IDLE: no request issued, stallreq=0, no LLbit write.
//  Timeout: BUS count reaching ACK_TIMEOUT -> bus_err pulse, dbus_req dropped, ->IDLE, wdata_o=0.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined:
//    - Misaligned LH/LHU/SH (addr[0]) or LW/SW/LL/SC (addr[1:0]!=0) raises out adel_o/ades_o (1 bit each, combinational).
//    - No bus access; no LLbit write.
//  Undefined: ports absent; low address bits select lanes only (word ops ignore addr[1:0]).
// STRUCTURE
//  Shared package mem_pkg: mem_op codes (OP_NONE, OP_LB..OP_SC), FSM state encoding, lane-select constants.
//  Sub-module mem_lane_align: combinational byte/half steering, sel generation, load extension.
// TESTING
//  LW addr 0x100, ack after 2 cycles, rdata 0xDEADBEEF -> req 2 cycles, wdata_o=0xDEADBEEF, stall 3 cycles total.
//  LB addr 0x103, rdata 0x000000F0 -> sel 4'b0001, wdata_o=0xFFFFFFF0; LBU -> 0x000000F0.
//  LL 0x200 then SC 0x200 with LLbit_i=1 -> LLbit_we/value 1/1, then SC store sel 4'b1111, wdata_o=1, LLbit value 0.
//  SC with LLbit_i=0 -> dbus_req never high, stallreq=0, wdata_o=0, LLbit_we_o=0.
//  Flush in BUS before ack -> dbus_req held until ack, then IDLE; LLbit_we_o stays 0.
//  ACK_TIMEOUT=4, no ack -> bus_err pulse after 4 BUS cycles, dbus_req=0; rst low mid-BUS -> all outputs 0 at once.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage load/store unit.
//   - mem_op codes driven by decode into mem_op (OP_NONE = no memory access)
//   - FSM state encoding of mem_llsc_unit
//   - big-endian byte-lane select constants
//   - small op-classification helpers
// Optional alignment checking in mem_llsc_unit is enabled by MEM_ALIGN_CHECK_EN.
package mem_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] OP_LL   = 4'd9;
  localparam logic [3:0] OP_SC   = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Big-endian lanes: byte address 0 lives in dbus bits [31:24].
  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_B0   = 4'b1000;
  localparam logic [3:0] SEL_HI   = 4'b1100;
  localparam logic [3:0] SEL_LO   = 4'b0011;
  localparam logic [3:0] SEL_W    = 4'b1111;

  // Codes above OP_SC are unassigned and treated as pass-through.
  function automatic logic op_is_mem(input logic [3:0] op);
    return (op != OP_NONE) && (op <= OP_SC);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SC);
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
    logic half_op;
    logic word_op;
    half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    word_op = (op == OP_LW) || (op == OP_SW) || (op == OP_LL) || (op == OP_SC);
    return (half_op && addr_lo[0]) || (word_op && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte/halfword steering for the load/store unit.
// Ports:
//   op         in  4   memory op code (mem_pkg)
//   addr_lo    in  2   low address bits selecting the big-endian lane
//   store_data in  32  store data (rt)
//   rdata      in  32  raw bus read data
//   sel        out 4   byte-lane enables
//   wdata_rep  out 32  store data replicated into every lane of its size
//   load_data  out 32  addressed lane, sign- or zero-extended
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Extract the addressed byte and halfword from the read data.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = rdata[31:24];
      2'd1:    byte_v = rdata[23:16];
      2'd2:    byte_v = rdata[15:8];
      default: byte_v = rdata[7:0];
    endcase
    if (addr_lo[1]) begin
      half_v = rdata[15:0];
    end else begin
      half_v = rdata[31:16];
    end
  end

  // Lane enables, store replication and load extension by access size.
  always_comb begin
    sel       = SEL_NONE;
    wdata_rep = 32'd0;
    load_data = 32'd0;
    case (op)
      OP_LB, OP_LBU, OP_SB: begin
        sel       = SEL_B0 >> addr_lo;
        wdata_rep = {4{store_data[7:0]}};
        load_data = (op == OP_LB) ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
      end
      OP_LH, OP_LHU, OP_SH: begin
        sel       = addr_lo[1] ? SEL_LO : SEL_HI;
        wdata_rep = {2{store_data[15:0]}};
        load_data = (op == OP_LH) ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
      end
      // Word accesses ignore addr_lo entirely.
      OP_LW, OP_SW, OP_LL, OP_SC: begin
        sel       = SEL_W;
        wdata_rep = store_data;
        load_data = rdata;
      end
      default: begin
        sel       = SEL_NONE;
        wdata_rep = 32'd0;
        load_data = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mem_llsc_unit.sv
// mem_llsc_unit: MEM-stage load/store unit with LL/SC support.
// Executes LB/LBU/LH/LHU/LW/SB/SH/SW/LL/SC over a req/ack data bus, stalls the
// pipeline while an access is outstanding, and produces the write-back value
// plus the LLbit update carried through MEM/WB.
// Parameter ACK_TIMEOUT: BUS/DRAIN cycles without ack before bus_err (0 = never).
// Optional build macro MEM_ALIGN_CHECK_EN adds adel_o/ades_o misalignment flags.
// Ports:
//   clk, rst (async, active-low), flush, mem_valid, mem_op[3:0], mem_addr[31:0],
//   mem_wdata[31:0], alu_result[31:0], LLbit_i, dbus_ack, dbus_rdata[31:0]  (in)
//   dbus_req, dbus_we, dbus_addr[31:0], dbus_sel[3:0], dbus_wdata[31:0],
//   wdata_o[31:0], stallreq, LLbit_we_o, LLbit_value_o, bus_err
//   [adel_o, ades_o with MEM_ALIGN_CHECK_EN]                                 (out)
module mem_llsc_unit
  import mem_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] alu_result,
  input  logic        LLbit_i,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  output logic [31:0] wdata_o,
  output logic        stallreq,
  output logic        LLbit_we_o,
  output logic        LLbit_value_o,
  output logic        bus_err
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        adel_o,
  output logic        ades_o
`endif
);

  localparam int            CW      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam bit            TO_EN   = (ACK_TIMEOUT != 0);
  localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);

  state_t        state, state_n;
  logic [3:0]    op_q;
  logic [1:0]    addr_lo_q;
  logic [31:0]   result_q;
  logic [CW-1:0] cnt;
  logic          launch, timeout, misaligned, in_bus;
  logic [3:0]    al_op;
  logic [1:0]    al_addr;
  logic [3:0]    lane_sel;
  logic [31:0]   lane_wdata, lane_load;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = op_misaligned(mem_op, mem_addr[1:0]);
  assign adel_o = rst && (state == ST_IDLE) && mem_valid && !flush && misaligned && !op_is_store(mem_op);
  assign ades_o = rst && (state == ST_IDLE) && mem_valid && !flush && misaligned && op_is_store(mem_op);
`else
  assign misaligned = 1'b0;
`endif

  // A failed SC never touches the bus. bus_err high means the timed-out
  // instruction is leaving MEM this cycle, so it must not be relaunched.
  assign launch = mem_valid && !flush && !bus_err && op_is_mem(mem_op) && !misaligned
                  && ((mem_op != OP_SC) || LLbit_i);

  assign in_bus  = (state == ST_BUS) || (state == ST_DRAIN);
  assign timeout = TO_EN && in_bus && !dbus_ack && (cnt == TO_LAST);

  // Steering uses the live op at launch and the latched op while the access runs.
  assign al_op   = (state == ST_IDLE) ? mem_op : op_q;
  assign al_addr = (state == ST_IDLE) ? mem_addr[1:0] : addr_lo_q;

  mem_lane_align u_align (
    .op         (al_op),
    .addr_lo    (al_addr),
    .store_data (mem_wdata),
    .rdata      (dbus_rdata),
    .sel        (lane_sel),
    .wdata_rep  (lane_wdata),
    .load_data  (lane_load)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and combinational outputs; all forced low while reset is held.
  always_comb begin
    state_n       = state;
    stallreq      = 1'b0;
    wdata_o       = 32'd0;
    LLbit_we_o    = 1'b0;
    LLbit_value_o = 1'b0;
    if (!rst) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            stallreq = 1'b1;
            state_n  = ST_BUS;
          end else if (mem_valid && !op_is_mem(mem_op)) begin
            wdata_o = alu_result;
          end else begin
            wdata_o = 32'd0;
          end
        end
        ST_BUS: begin
          stallreq = 1'b1;
          if (dbus_ack) begin
            state_n = flush ? ST_IDLE : ST_DONE;
          end else if (timeout) begin
            state_n = ST_IDLE;
          end else if (flush) begin
            state_n = ST_DRAIN;
          end else begin
            state_n = ST_BUS;
          end
        end
        // The bus cannot abort a transfer: hold the pipe until it completes.
        ST_DRAIN: begin
          stallreq = 1'b1;
          if (dbus_ack || timeout) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DRAIN;
          end
        end
        ST_DONE: begin
          wdata_o = result_q;
          state_n = ST_IDLE;
          if (!flush && (op_q == OP_LL)) begin
            LLbit_we_o    = 1'b1;
            LLbit_value_o = 1'b1;
          end else if (!flush && (op_q == OP_SC)) begin
            LLbit_we_o    = 1'b1;
            LLbit_value_o = 1'b0;
          end else begin
            LLbit_we_o    = 1'b0;
            LLbit_value_o = 1'b0;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // Registered bus request: loaded at launch, held until ack or timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 32'd0;
      dbus_sel   <= 4'd0;
      dbus_wdata <= 32'd0;
      op_q       <= OP_NONE;
      addr_lo_q  <= 2'd0;
    end else if ((state == ST_IDLE) && launch) begin
      dbus_req   <= 1'b1;
      dbus_we    <= op_is_store(mem_op);
      dbus_addr  <= {mem_addr[31:2], 2'b00};
      dbus_sel   <= lane_sel;
      dbus_wdata <= lane_wdata;
      op_q       <= mem_op;
      addr_lo_q  <= mem_addr[1:0];
    end else if (in_bus && (dbus_ack || timeout)) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 32'd0;
      dbus_sel   <= 4'd0;
      dbus_wdata <= 32'd0;
    end else begin
      dbus_req   <= dbus_req;
    end
  end

  // Ack-wait counter, timeout pulse and write-back result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= {CW{1'b0}};
      bus_err  <= 1'b0;
      result_q <= 32'd0;
    end else begin
      bus_err <= timeout;
      if (in_bus && !dbus_ack && !timeout) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= {CW{1'b0}};
      end
      if ((state == ST_BUS) && dbus_ack) begin
        if (op_is_store(op_q)) begin
          result_q <= (op_q == OP_SC) ? 32'd1 : 32'd0;
        end else begin
          result_q <= lane_load;
        end
      end else begin
        result_q <= result_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_llsc_unit.sv
module tb_mem_llsc_unit;
  import mem_pkg::*;

  logic        clk, rst, flush, mem_valid, LLbit_i, dbus_ack;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr, mem_wdata, alu_result, dbus_rdata;
  logic        dbus_req, dbus_we, stallreq, LLbit_we_o, LLbit_value_o, bus_err;
  logic [31:0] dbus_addr, dbus_wdata, wdata_o;
  logic [3:0]  dbus_sel;

  mem_llsc_unit #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .mem_valid(mem_valid), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .alu_result(alu_result), .LLbit_i(LLbit_i),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata), .wdata_o(wdata_o),
    .stallreq(stallreq), .LLbit_we_o(LLbit_we_o), .LLbit_value_o(LLbit_value_o), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  string       tag_q[$];
  logic [31:0] val_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  int          r_stall, r_req;
  logic [3:0]  r_sel;
  logic        r_we, r_llwe, r_llval, r_done, llwe_seen;
  logic [31:0] r_addr, r_bwd, r_res;
  int          n_to;

  task automatic sb_push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    val_q.push_back(v);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    string       t;
    logic [31:0] v;
    n_assert++;
    if (val_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h, nothing expected", obs);
    end else begin
      t = tag_q.pop_front();
      v = val_q.pop_front();
      assert (obs === v) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", t, obs, v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one MEM instruction, ack on the ack_after-th request cycle, run until stall drops.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic ll, input int ack_after, input logic [31:0] rd);
    r_stall = 0; r_req = 0; r_sel = 4'd0; r_we = 1'b0; r_addr = 32'd0; r_bwd = 32'd0;
    r_res = 32'hxxxxxxxx; r_llwe = 1'b0; r_llval = 1'b0; r_done = 1'b0;
    tick();
    mem_valid = 1'b1; mem_op = op; mem_addr = addr; mem_wdata = wd; LLbit_i = ll;
    dbus_ack = 1'b0; dbus_rdata = 32'd0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin
        tick();
        if (dbus_req) begin
          r_req++;
          r_sel = dbus_sel; r_we = dbus_we; r_addr = dbus_addr; r_bwd = dbus_wdata;
          dbus_ack = (r_req == ack_after);
          dbus_rdata = rd;
        end else begin
          dbus_ack = 1'b0;
        end
      end
      @(negedge clk);
      if (stallreq) begin
        r_stall++;
      end else begin
        r_res = wdata_o; r_llwe = LLbit_we_o; r_llval = LLbit_value_o; r_done = 1'b1;
        break;
      end
    end
    tick();
    dbus_ack = 1'b0; mem_valid = 1'b0; mem_op = OP_NONE; LLbit_i = 1'b0;
  endtask

  task automatic expect_op(input string t, input logic [31:0] res, input int stall, input int req,
                           input logic [3:0] sel, input logic we, input logic llwe, input logic llval);
    sb_push({t, ".done"}, 32'd1);
    sb_push({t, ".wdata_o"}, res);
    sb_push({t, ".stall_cycles"}, 32'(stall));
    sb_push({t, ".req_cycles"}, 32'(req));
    sb_push({t, ".sel"}, {28'd0, sel});
    sb_push({t, ".we"}, {31'd0, we});
    sb_push({t, ".llbit_we"}, {31'd0, llwe});
    sb_push({t, ".llbit_value"}, {31'd0, llval});
  endtask

  task automatic check_op();
    sb_check({31'd0, r_done});
    sb_check(r_res);
    sb_check(32'(r_stall));
    sb_check(32'(r_req));
    sb_check({28'd0, r_sel});
    sb_check({31'd0, r_we});
    sb_check({31'd0, r_llwe});
    sb_check({31'd0, r_llval});
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; mem_valid = 1'b0; mem_op = OP_NONE; mem_addr = 32'd0;
    mem_wdata = 32'd0; alu_result = 32'd0; LLbit_i = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'd0;

    // Reset state
    sb_push("rst.dbus_req", 32'd0);   sb_push("rst.dbus_we", 32'd0);
    sb_push("rst.dbus_sel", 32'd0);   sb_push("rst.dbus_addr", 32'd0);
    sb_push("rst.dbus_wdata", 32'd0); sb_push("rst.wdata_o", 32'd0);
    sb_push("rst.llbit_we", 32'd0);   sb_push("rst.bus_err", 32'd0);
    sb_push("rst.stallreq", 32'd0);
    @(negedge clk); @(negedge clk);
    sb_check({31'd0, dbus_req});  sb_check({31'd0, dbus_we});
    sb_check({28'd0, dbus_sel});  sb_check(dbus_addr);
    sb_check(dbus_wdata);         sb_check(wdata_o);
    sb_check({31'd0, LLbit_we_o}); sb_check({31'd0, bus_err});
    sb_check({31'd0, stallreq});
    tick();
    rst = 1'b1;

    // LW, ack in the second request cycle
    expect_op("lw", 32'hDEADBEEF, 3, 2, 4'b1111, 1'b0, 1'b0, 1'b0);
    sb_push("lw.dbus_addr", 32'h0000_0100);
    do_op(OP_LW, 32'h0000_0100, 32'd0, 1'b0, 2, 32'hDEADBEEF);
    check_op(); sb_check(r_addr);

    // Byte/half loads across lanes, minimum latency
    expect_op("lb3", 32'hFFFFFFF0, 2, 1, 4'b0001, 1'b0, 1'b0, 1'b0);
    do_op(OP_LB, 32'h0000_0103, 32'd0, 1'b0, 1, 32'h0000_00F0);
    check_op();
    expect_op("lbu3", 32'h000000F0, 2, 1, 4'b0001, 1'b0, 1'b0, 1'b0);
    do_op(OP_LBU, 32'h0000_0103, 32'd0, 1'b0, 1, 32'h0000_00F0);
    check_op();
    expect_op("lb0", 32'hFFFFFF80, 2, 1, 4'b1000, 1'b0, 1'b0, 1'b0);
    do_op(OP_LB, 32'h0000_0100, 32'd0, 1'b0, 1, 32'h8000_0000);
    check_op();
    expect_op("lh2", 32'hFFFF8001, 2, 1, 4'b0011, 1'b0, 1'b0, 1'b0);
    do_op(OP_LH, 32'h0000_0102, 32'd0, 1'b0, 1, 32'h0000_8001);
    check_op();
    expect_op("lhu0", 32'h00008001, 2, 1, 4'b1100, 1'b0, 1'b0, 1'b0);
    do_op(OP_LHU, 32'h0000_0100, 32'd0, 1'b0, 1, 32'h8001_ABCD);
    check_op();

    // Stores: lane replication and word-aligned bus address
    expect_op("sb1", 32'd0, 2, 1, 4'b0100, 1'b1, 1'b0, 1'b0);
    sb_push("sb1.dbus_wdata", 32'h78787878); sb_push("sb1.dbus_addr", 32'h0000_0100);
    do_op(OP_SB, 32'h0000_0101, 32'h12345678, 1'b0, 1, 32'd0);
    check_op(); sb_check(r_bwd); sb_check(r_addr);
    expect_op("sh2", 32'd0, 2, 1, 4'b0011, 1'b1, 1'b0, 1'b0);
    sb_push("sh2.dbus_wdata", 32'h55555555);
    do_op(OP_SH, 32'h0000_0102, 32'hAAAA5555, 1'b0, 1, 32'd0);
    check_op(); sb_check(r_bwd);

    // Pass-through op
    alu_result = 32'hCAFEF00D;
    expect_op("none", 32'hCAFEF00D, 0, 0, 4'b0000, 1'b0, 1'b0, 1'b0);
    do_op(OP_NONE, 32'h0000_0100, 32'd0, 1'b0, 1, 32'd0);
    check_op();

    // LL then successful SC
    expect_op("ll", 32'h11111111, 2, 1, 4'b1111, 1'b0, 1'b1, 1'b1);
    do_op(OP_LL, 32'h0000_0200, 32'd0, 1'b0, 1, 32'h11111111);
    check_op();
    expect_op("sc_ok", 32'd1, 3, 2, 4'b1111, 1'b1, 1'b1, 1'b0);
    sb_push("sc_ok.dbus_wdata", 32'h0000_0077); sb_push("sc_ok.dbus_addr", 32'h0000_0200);
    do_op(OP_SC, 32'h0000_0200, 32'h0000_0077, 1'b1, 2, 32'd0);
    check_op(); sb_check(r_bwd); sb_check(r_addr);

    // Failed SC: no bus, no stall, result 0
    expect_op("sc_fail", 32'd0, 0, 0, 4'b0000, 1'b0, 1'b0, 1'b0);
    do_op(OP_SC, 32'h0000_0200, 32'h0000_0077, 1'b0, 1, 32'd0);
    check_op();

    // Flush while IDLE: nothing launched
    sb_push("fi.stallreq", 32'd0); sb_push("fi.llbit_we", 32'd0); sb_push("fi.dbus_req", 32'd0);
    tick();
    mem_valid = 1'b1; mem_op = OP_LW; mem_addr = 32'h0000_0600; flush = 1'b1;
    @(negedge clk);
    sb_check({31'd0, stallreq}); sb_check({31'd0, LLbit_we_o});
    tick();
    flush = 1'b0; mem_valid = 1'b0; mem_op = OP_NONE;
    @(negedge clk);
    sb_check({31'd0, dbus_req});

    // Flush during BUS: request held until ack, no LLbit write
    sb_push("fb.req_flush", 32'd1); sb_push("fb.req_drain", 32'd1); sb_push("fb.stall_drain", 32'd1);
    sb_push("fb.req_ack", 32'd1);   sb_push("fb.req_after", 32'd0); sb_push("fb.stall_after", 32'd0);
    sb_push("fb.llbit_we_any", 32'd0);
    llwe_seen = 1'b0;
    tick();
    mem_valid = 1'b1; mem_op = OP_LL; mem_addr = 32'h0000_0300;
    @(negedge clk); llwe_seen = llwe_seen | LLbit_we_o;
    tick();
    flush = 1'b1;
    @(negedge clk); llwe_seen = llwe_seen | LLbit_we_o;
    sb_check({31'd0, dbus_req});
    tick();
    flush = 1'b0; mem_valid = 1'b0; mem_op = OP_NONE;
    @(negedge clk); llwe_seen = llwe_seen | LLbit_we_o;
    sb_check({31'd0, dbus_req}); sb_check({31'd0, stallreq});
    tick();
    dbus_ack = 1'b1; dbus_rdata = 32'h5555_5555;
    @(negedge clk); llwe_seen = llwe_seen | LLbit_we_o;
    sb_check({31'd0, dbus_req});
    tick();
    dbus_ack = 1'b0;
    @(negedge clk); llwe_seen = llwe_seen | LLbit_we_o;
    sb_check({31'd0, dbus_req}); sb_check({31'd0, stallreq});
    sb_check({31'd0, llwe_seen});

    // Ack timeout (ACK_TIMEOUT = 4)
    sb_push("to.req_cycles", 32'd4); sb_push("to.bus_err", 32'd1); sb_push("to.dbus_req", 32'd0);
    sb_push("to.wdata_o", 32'd0);    sb_push("to.stallreq", 32'd0); sb_push("to.bus_err_pulse", 32'd0);
    tick();
    mem_valid = 1'b1; mem_op = OP_LW; mem_addr = 32'h0000_0400;
    n_to = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      @(negedge clk);
      if (bus_err) break;
      if (dbus_req) n_to++;
    end
    sb_check(32'(n_to)); sb_check({31'd0, bus_err}); sb_check({31'd0, dbus_req});
    sb_check(wdata_o);   sb_check({31'd0, stallreq});
    tick();
    mem_valid = 1'b0; mem_op = OP_NONE;
    @(negedge clk);
    sb_check({31'd0, bus_err});

    // Asynchronous reset in the middle of a store
    sb_push("ar.req_before", 32'd1); sb_push("ar.dbus_req", 32'd0); sb_push("ar.dbus_we", 32'd0);
    sb_push("ar.dbus_sel", 32'd0);   sb_push("ar.dbus_addr", 32'd0); sb_push("ar.dbus_wdata", 32'd0);
    sb_push("ar.stallreq", 32'd0);   sb_push("ar.wdata_o", 32'd0);   sb_push("ar.req_after_release", 32'd0);
    tick();
    mem_valid = 1'b1; mem_op = OP_SW; mem_addr = 32'h0000_0500; mem_wdata = 32'h0000_0099;
    tick();
    #2;
    sb_check({31'd0, dbus_req});
    rst = 1'b0;
    #1;
    sb_check({31'd0, dbus_req}); sb_check({31'd0, dbus_we}); sb_check({28'd0, dbus_sel});
    sb_check(dbus_addr);         sb_check(dbus_wdata);       sb_check({31'd0, stallreq});
    sb_check(wdata_o);
    mem_valid = 1'b0; mem_op = OP_NONE;
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    sb_check({31'd0, dbus_req});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
